// File: rtl/meco_cmd_pkg.sv
// Mecobo command sequencer shared definitions.
// Instruction word layout, opcodes and one-hot FSM encoding.
package meco_cmd_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PROG = 3'd1;
  localparam logic [2:0] OP_READ = 3'd2;

  localparam int B_VALID = 15;
  localparam int B_OP_HI = 14;
  localparam int B_OP_LO = 12;
  localparam int B_ERR   = 11;
  localparam int B_CH_HI = 7;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic       err;
    logic [2:0] rsvd;
    logic [7:0] chan;
  } instr_t;

  typedef enum logic [8:0] {
    S_IDLE     = 9'b000000001,
    S_FETCH    = 9'b000000010,
    S_DECODE   = 9'b000000100,
    S_LOAD     = 9'b000001000,
    S_SEND     = 9'b000010000,
    S_RD_REQ   = 9'b000100000,
    S_RD_WAIT  = 9'b001000000,
    S_RD_WRITE = 9'b010000000,
    S_ACK      = 9'b100000000
  } state_t;

  function automatic logic [15:0] ack_word(
    input logic [2:0] op,
    input logic       err,
    input logic [7:0] chan
  );
    instr_t w;
    w.valid = 1'b0;
    w.op    = op;
    w.err   = err;
    w.rsvd  = 3'b000;
    w.chan  = chan;
    return w;
  endfunction

endpackage

// File: rtl/meco_cmd_timeout.sv
// Sample-wait watchdog for the command sequencer.
// Loads TIMEOUT-1 on clear, counts down while enabled, flags zero.
module meco_cmd_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= W'(TIMEOUT - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/meco_command_seq.sv
// Mecobo command sequencer: polls the instruction word in shared RAM,
// streams pin configs or reads a sample back, then acknowledges.
module meco_command_seq
  import meco_cmd_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 21,
  parameter int                    DATA_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] INSTR_ADDR   = 'h42,
  parameter int                    NUM_CHANNELS = 8,
  parameter int                    CFG_WORDS    = 4,
  parameter int                    TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_wr,
  output logic                  ram_en,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [7:0]            cfg_chan,
  output logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  cfg_last,
  output logic                  smp_req,
  output logic [7:0]            smp_chan,
  input  logic                  smp_valid,
  input  logic [DATA_WIDTH-1:0] smp_data,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           instr_count
);

  state_t                state;
  state_t                nxt;
  instr_t                word;
  logic [2:0]            op_q;
  logic [7:0]            chan_q;
  logic                  err_q;
  logic                  error_q;
  logic [3:0]            k;
  logic [DATA_WIDTH-1:0] cfg_q;
  logic [DATA_WIDTH-1:0] smp_q;
  logic                  fresh_q;
  logic [15:0]           cnt_q;
  logic                  tmr_clr;
  logic                  tmr_en;
  logic                  tmr_exp;
  logic                  chan_ok;
  logic                  is_nop;
  logic                  prog_ok;
  logic                  read_ok;
  logic                  bad_op;
  logic                  last_k;
  logic [ADDR_WIDTH-1:0] pay_addr;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic                  unused_word;

  assign word        = instr_t'(ram_data_in[15:0]);
  assign unused_word = ^{word.err, word.rsvd};

  assign chan_ok  = {1'b0, chan_q} < 9'(NUM_CHANNELS);
  assign is_nop   = (op_q == OP_NOP);
  assign prog_ok  = (op_q == OP_PROG) && chan_ok;
  assign read_ok  = (op_q == OP_READ) && chan_ok;
  assign bad_op   = !(is_nop || prog_ok || read_ok);
  assign last_k   = (k == 4'(CFG_WORDS - 1));
  assign res_addr = INSTR_ADDR + ADDR_WIDTH'(1);
  assign pay_addr = res_addr + ADDR_WIDTH'(k);

  meco_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      chan_q  <= '0;
      err_q   <= 1'b0;
      error_q <= 1'b0;
      k       <= '0;
      cfg_q   <= '0;
      smp_q   <= '0;
      fresh_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= nxt;
      fresh_q <= (state == S_LOAD);
      if (state == S_FETCH) begin
        op_q   <= word.op;
        chan_q <= word.chan;
        err_q  <= 1'b0;
      end
      if (state == S_DECODE) begin
        k <= '0;
        if (bad_op) begin
          err_q   <= 1'b1;
          error_q <= 1'b1;
        end
      end
      if (fresh_q) cfg_q <= ram_data_in;
      if (state == S_SEND && cfg_ready) k <= k + 1'b1;
      if (state == S_RD_WAIT) begin
        if (smp_valid) begin
          smp_q <= smp_data;
        end else if (tmr_exp) begin
          err_q   <= 1'b1;
          error_q <= 1'b1;
        end
      end
      if (state == S_ACK) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    nxt          = state;
    ram_addr     = INSTR_ADDR;
    ram_en       = 1'b0;
    ram_wr       = 1'b0;
    ram_data_out = '0;
    cfg_valid    = 1'b0;
    cfg_last     = 1'b0;
    smp_req      = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    unique case (state)
      S_IDLE: begin
        // keep the port quiet while held in reset
        ram_en = reset;
        nxt    = S_FETCH;
      end
      S_FETCH: begin
        nxt = word.valid ? S_DECODE : S_IDLE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_nop:  nxt = S_ACK;
          prog_ok: nxt = S_LOAD;
          read_ok: nxt = S_RD_REQ;
          bad_op:  nxt = S_ACK;
        endcase
      end
      S_LOAD: begin
        ram_en   = 1'b1;
        ram_addr = pay_addr;
        nxt      = S_SEND;
      end
      S_SEND: begin
        cfg_valid = 1'b1;
        cfg_last  = last_k;
        if (cfg_ready) nxt = last_k ? S_ACK : S_LOAD;
      end
      S_RD_REQ: begin
        smp_req = 1'b1;
        tmr_clr = 1'b1;
        nxt     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tmr_en = 1'b1;
        if (smp_valid) nxt = S_RD_WRITE;
        else if (tmr_exp) nxt = S_ACK;
      end
      S_RD_WRITE: begin
        ram_en       = 1'b1;
        ram_wr       = 1'b1;
        ram_addr     = res_addr;
        ram_data_out = smp_q;
        nxt          = S_ACK;
      end
      S_ACK: begin
        ram_en       = 1'b1;
        ram_wr       = 1'b1;
        ram_data_out = DATA_WIDTH'(ack_word(op_q, err_q, chan_q));
        nxt          = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // first SEND cycle forwards the RAM output, later cycles the held copy
  assign cfg_data    = (state != S_SEND) ? '0 :
                       fresh_q ? ram_data_in : cfg_q;
  assign cfg_chan    = (state == S_SEND) ? chan_q : '0;
  assign smp_chan    = (state == S_RD_REQ) ? chan_q : '0;
  assign busy        = !(state == S_IDLE || state == S_FETCH);
  assign error       = error_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_meco_command_seq.sv
// Directed bench for meco_command_seq with a shared-RAM model.
// Small window of the RAM is modelled; uC writes go through port A.
module tb_meco_command_seq;

  localparam int AW = 21;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          ram_wr;
  logic          ram_en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_chan;
  logic [DW-1:0] cfg_data;
  logic          cfg_last;
  logic          smp_req;
  logic [7:0]    smp_chan;
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic          busy;
  logic          error;
  logic [15:0]   instr_count;

  always #5 clk = ~clk;

  meco_command_seq #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .INSTR_ADDR   (21'h42),
    .NUM_CHANNELS (8),
    .CFG_WORDS    (4),
    .TIMEOUT      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .ram_wr       (ram_wr),
    .ram_en       (ram_en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_chan     (cfg_chan),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .smp_req      (smp_req),
    .smp_chan     (smp_chan),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .busy         (busy),
    .error        (error),
    .instr_count  (instr_count)
  );

  logic [15:0] mem [0:127];
  logic [15:0] ram_rd;
  logic        uc_we;
  logic [6:0]  uc_a;
  logic [15:0] uc_d;
  int          cyc = 0;
  int          uc_c = 0;
  int          req_c = 0;
  int          cfg_vcnt = 0;
  int          smp_cnt = 0;
  int          stall_bad = 0;
  logic        held = 1'b0;
  logic [23:0] held_v = '0;
  logic [AW-1:0] wa_q [$];
  logic [15:0]   wd_q [$];
  int            wc_q [$];
  logic [24:0]   xq [$];
  int tests = 0;
  int fails = 0;

  assign ram_data_in = ram_rd;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uc_we) begin
      mem[uc_a] <= uc_d;
      uc_c <= cyc;
    end
    if (ram_en) begin
      if (ram_wr) begin
        mem[ram_addr[6:0]] <= ram_data_out;
        wa_q.push_back(ram_addr);
        wd_q.push_back(ram_data_out);
        wc_q.push_back(cyc);
      end
      ram_rd <= mem[ram_addr[6:0]];
    end
  end

  always @(posedge clk) begin
    if (cfg_valid) cfg_vcnt <= cfg_vcnt + 1;
    if (cfg_valid && cfg_ready)
      xq.push_back({cfg_last, cfg_chan, cfg_data});
    if (smp_req) begin
      smp_cnt <= smp_cnt + 1;
      req_c <= cyc;
    end
    if (held && reset &&
        (!cfg_valid || {cfg_chan, cfg_data} != held_v))
      stall_bad <= stall_bad + 1;
    held   <= reset && cfg_valid && !cfg_ready;
    held_v <= {cfg_chan, cfg_data};
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic uc_write(input logic [6:0] a, input logic [15:0] d);
    uc_we = 1'b1;
    uc_a  = a;
    uc_d  = d;
    step(1);
    uc_we = 1'b0;
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    xq.delete();
  endtask

  task automatic wait_wr(input int n, input int budget, input int mode);
    int b;
    b = 0;
    while (wa_q.size() < n && b < budget) begin
      if (mode == 1) cfg_ready = ~cfg_ready;
      else if (mode == 2) cfg_ready = (b % 3 == 2);
      step(1);
      b++;
    end
    cfg_ready = 1'b0;
    check("wr_count", 64'(wa_q.size()), 64'(n));
  endtask

  task automatic wait_req(input int budget);
    int b;
    b = 0;
    while (!smp_req && b < budget) begin
      step(1);
      b++;
    end
    check("req_seen", 64'(smp_req), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int s0;
    int b;
    int lat;
    reset = 1'b0;
    cfg_ready = 1'b0;
    smp_valid = 1'b0;
    smp_data = '0;
    uc_we = 1'b0;
    uc_a = '0;
    uc_d = '0;
    step(2);
    uc_write(7'h42, 16'h0000);
    uc_write(7'h43, 16'h1111);
    for (int i = 4; i < 8; i++) uc_write(7'h40 + 7'(i), 16'h0000);

    check("rst_ctl",
          64'({ram_en, ram_wr, cfg_valid, smp_req, busy, error}), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'h42);
    check("rst_data", 64'({ram_data_out, cfg_data}), 64'd0);

    reset = 1'b1;
    step(6);
    check("idle_nowr", 64'(wa_q.size()), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // NOP
    clear_logs();
    v0 = cfg_vcnt;
    s0 = smp_cnt;
    uc_write(7'h42, 16'h8000);
    wait_wr(1, 10, 0);
    lat = wc_q[0] - uc_c;
    check("nop_addr", 64'(wa_q[0]), 64'h42);
    check("nop_data", 64'(wd_q[0]), 64'h0000);
    check("nop_lat", 64'(lat == 4 || lat == 5), 64'd1);
    check("nop_count", 64'(instr_count), 64'd1);
    check("nop_quiet", 64'({cfg_vcnt - v0, smp_cnt - s0}), 64'd0);

    // PROGRAM ch3, ready toggling
    uc_write(7'h43, 16'h00A1);
    uc_write(7'h44, 16'h00B2);
    uc_write(7'h45, 16'h00C3);
    uc_write(7'h46, 16'h00D4);
    clear_logs();
    s0 = stall_bad;
    uc_write(7'h42, 16'h9003);
    wait_wr(1, 60, 1);
    check("prog_n", 64'(xq.size()), 64'd4);
    if (xq.size() == 4) begin
      check("prog_data",
            {xq[0][15:0], xq[1][15:0], xq[2][15:0], xq[3][15:0]},
            64'h00A1_00B2_00C3_00D4);
      check("prog_chan",
            64'({xq[0][23:16], xq[1][23:16], xq[2][23:16], xq[3][23:16]}),
            64'h03030303);
      check("prog_last",
            64'({xq[0][24], xq[1][24], xq[2][24], xq[3][24]}), 64'b0001);
    end
    check("prog_stable", 64'(stall_bad - s0), 64'd0);
    check("prog_ack", 64'({wa_q[0], wd_q[0]}), {27'd0, 21'h42, 16'h1003});
    check("prog_count", 64'(instr_count), 64'd2);

    // READ ch5, sample after 7 cycles
    clear_logs();
    s0 = smp_cnt;
    uc_write(7'h42, 16'hA005);
    wait_req(20);
    check("rd_chan", 64'(smp_chan), 64'd5);
    step(7);
    smp_valid = 1'b1;
    smp_data = 16'h5A5A;
    step(1);
    smp_valid = 1'b0;
    smp_data = '0;
    wait_wr(2, 10, 0);
    if (wa_q.size() == 2) begin
      check("rd_res", 64'({wa_q[0], wd_q[0]}), {27'd0, 21'h43, 16'h5A5A});
      check("rd_ack", 64'({wa_q[1], wd_q[1]}), {27'd0, 21'h42, 16'h2005});
    end
    check("rd_pulse", 64'(smp_cnt - s0), 64'd1);
    check("rd_mem", 64'(mem[7'h43]), 64'h5A5A);
    check("rd_err", 64'(error), 64'd0);

    // READ ch2, no sample: timeout
    uc_write(7'h43, 16'h1234);
    clear_logs();
    uc_write(7'h42, 16'hA002);
    wait_req(20);
    wait_wr(1, 40, 0);
    check("to_ack", 64'({wa_q[0], wd_q[0]}), {27'd0, 21'h42, 16'h2802});
    check("to_lat", 64'(wc_q[0] - req_c), 64'd17);
    check("to_err", 64'(error), 64'd1);
    check("to_mem", 64'(mem[7'h43]), 64'h1234);
    check("to_count", 64'(instr_count), 64'd4);

    // illegal opcode, then channel out of range
    clear_logs();
    v0 = cfg_vcnt;
    uc_write(7'h42, 16'hF001);
    wait_wr(1, 10, 0);
    check("ill_ack", 64'(wd_q[0]), 64'h7801);
    clear_logs();
    uc_write(7'h42, 16'h9009);
    wait_wr(1, 10, 0);
    check("ch_ack", 64'(wd_q[0]), 64'h1809);
    check("ill_nocfg", 64'(cfg_vcnt - v0), 64'd0);
    check("ill_count", 64'(instr_count), 64'd6);
    check("ill_err", 64'(error), 64'd1);

    // reset during second word of a burst
    uc_write(7'h43, 16'h0011);
    uc_write(7'h44, 16'h0022);
    uc_write(7'h45, 16'h0033);
    uc_write(7'h46, 16'h0044);
    clear_logs();
    uc_write(7'h42, 16'h9004);
    cfg_ready = 1'b1;
    b = 0;
    while (xq.size() < 1 && b < 30) begin
      step(1);
      b++;
    end
    cfg_ready = 1'b0;
    check("rst_w1", 64'(xq.size()), 64'd1);
    step(1);
    check("rst_w2a", 64'({cfg_valid, cfg_last, cfg_data}), 64'h20022);
    step(1);
    check("rst_w2b", 64'({cfg_valid, cfg_last, cfg_data}), 64'h20022);
    #3;
    reset = 1'b0;
    #1;
    check("rst_async", 64'({cfg_valid, smp_req, busy}), 64'd0);
    step(2);
    check("rst_nowr", 64'(wa_q.size()), 64'd0);
    check("rst_mem", 64'(mem[7'h42]), 64'h9004);
    reset = 1'b1;
    check("rst_idle",
          64'({busy, error, instr_count}), 64'd0);
    xq.delete();
    s0 = stall_bad;
    wait_wr(1, 80, 2);
    check("rep_n", 64'(xq.size()), 64'd4);
    if (xq.size() == 4) begin
      check("rep_data",
            {xq[0][15:0], xq[1][15:0], xq[2][15:0], xq[3][15:0]},
            64'h0011_0022_0033_0044);
      check("rep_last",
            64'({xq[0][24], xq[1][24], xq[2][24], xq[3][24]}), 64'b0001);
    end
    check("rep_stable", 64'(stall_bad - s0), 64'd0);
    check("rep_ack", 64'({wa_q[0], wd_q[0]}), {27'd0, 21'h42, 16'h1004});
    check("rep_count", 64'(instr_count), 64'd1);

    step(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
